match_referee: RTL and testbench

MATCH_REFEREE -- requirements
Module: match_referee

---
 rtl/match_referee_if.sv | 26 ++
 rtl/match_referee.sv | 109 ++++++++++
 tb/tb_match_referee.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/match_referee_if.sv
// Match referee bus: match control and round results in, scores and verdict out.
interface match_referee_if;
    logic       Start;
    logic [3:0] Target;
    logic       Round_valid;
    logic [1:0] Out_wr;
    logic [3:0] Score_first;
    logic [3:0] Score_second;
    logic [3:0] Draws;
    logic [3:0] Round_count;
    logic       Busy;
    logic       Match_over;
    logic [1:0] Champion;

    // Driver side: issues Start/rounds, observes the scoreboard.
    modport master (
        output Start, Target, Round_valid, Out_wr,
        input  Score_first, Score_second, Draws, Round_count, Busy, Match_over, Champion
    );

    // Referee side.
    modport slave (
        input  Start, Target, Round_valid, Out_wr,
        output Score_first, Score_second, Draws, Round_count, Busy, Match_over, Champion
    );
endinterface

// File: rtl/match_referee.sv
// Match referee: counts round results from the winner stage and declares a
// champion once a player reaches the latched target or 15 rounds are played.
module match_referee (
    input  logic          Clock,
    input  logic          Reset,
    match_referee_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

    localparam logic [1:0] ChampNone   = 2'b00;
    localparam logic [1:0] ChampFirst  = 2'b10;
    localparam logic [1:0] ChampSecond = 2'b01;
    localparam logic [1:0] ChampTie    = 2'b11;

    state_e     state_q, state_d;
    logic [3:0] first_q, first_d;
    logic [3:0] second_q, second_d;
    logic [3:0] draws_q, draws_d;
    logic [3:0] round_q, round_d;
    logic [3:0] target_q, target_d;
    logic [1:0] champ_q, champ_d;
    logic       busy_q, busy_d;
    logic       over_q, over_d;

    // Next-state: Start restarts from any state; rounds only count while playing.
    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        second_d = second_q;
        draws_d  = draws_q;
        round_d  = round_q;
        target_d = target_q;
        champ_d  = champ_q;

        if (bus.Start) begin
            // A round arriving with Start is dropped; the new match starts clean.
            first_d  = 4'd0;
            second_d = 4'd0;
            draws_d  = 4'd0;
            round_d  = 4'd0;
            champ_d  = ChampNone;
            target_d = (bus.Target == 4'd0) ? 4'd1 : bus.Target;
            state_d  = StPlay;
        end else if (state_q == StPlay && bus.Round_valid && bus.Out_wr != 2'b00) begin
            round_d = round_q + 4'd1;
            case (bus.Out_wr)
                2'b10:   first_d  = first_q + 4'd1;
                2'b01:   second_d = second_q + 4'd1;
                default: draws_d  = draws_q + 4'd1;
            endcase

            // Reaching the target wins outright, even on the 15th round.
            if (first_d == target_q) begin
                state_d = StDone;
                champ_d = ChampFirst;
            end else if (second_d == target_q) begin
                state_d = StDone;
                champ_d = ChampSecond;
            end else if (round_d == 4'd15) begin
                state_d = StDone;
                if (first_d > second_d) begin
                    champ_d = ChampFirst;
                end else if (second_d > first_d) begin
                    champ_d = ChampSecond;
                end else begin
                    champ_d = ChampTie;
                end
            end
        end

        busy_d = (state_d == StPlay);
        over_d = (state_d == StDone);
    end

    // State and registered outputs; synchronous reset wins over everything.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StIdle;
            first_q  <= 4'd0;
            second_q <= 4'd0;
            draws_q  <= 4'd0;
            round_q  <= 4'd0;
            target_q <= 4'd1;
            champ_q  <= ChampNone;
            busy_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            second_q <= second_d;
            draws_q  <= draws_d;
            round_q  <= round_d;
            target_q <= target_d;
            champ_q  <= champ_d;
            busy_q   <= busy_d;
            over_q   <= over_d;
        end
    end

    assign bus.Score_first  = first_q;
    assign bus.Score_second = second_q;
    assign bus.Draws        = draws_q;
    assign bus.Round_count  = round_q;
    assign bus.Busy         = busy_q;
    assign bus.Match_over   = over_q;
    assign bus.Champion     = champ_q;

endmodule

// File: tb/tb_match_referee.sv
// Directed vector bench for match_referee.
module tb_match_referee;

    logic Clock;
    logic Reset;

    match_referee_if bus ();

    match_referee dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string      name;
        logic       rst;
        logic       start;
        logic [3:0] target;
        logic       rv;
        logic [1:0] ow;
        logic [3:0] e_first;
        logic [3:0] e_second;
        logic [3:0] e_draws;
        logic [3:0] e_rounds;
        logic       e_busy;
        logic       e_over;
        logic [1:0] e_champ;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input string name, input logic rst, input logic start,
                       input logic [3:0] target, input logic rv, input logic [1:0] ow,
                       input logic [3:0] f, input logic [3:0] s, input logic [3:0] d,
                       input logic [3:0] rc, input logic busy, input logic over,
                       input logic [1:0] ch);
        vec_t v;
        v.name = name; v.rst = rst; v.start = start; v.target = target; v.rv = rv; v.ow = ow;
        v.e_first = f; v.e_second = s; v.e_draws = d; v.e_rounds = rc;
        v.e_busy = busy; v.e_over = over; v.e_champ = ch;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, clock it, then sample just after the edge.
    task automatic step(input logic rst, input logic start, input logic [3:0] target,
                        input logic rv, input logic [1:0] ow);
        @(negedge Clock);
        Reset           = rst;
        bus.Start       = start;
        bus.Target      = target;
        bus.Round_valid = rv;
        bus.Out_wr      = ow;
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] f, input logic [3:0] s,
                         input logic [3:0] d, input logic [3:0] rc, input logic busy,
                         input logic over, input logic [1:0] ch);
        logic [19:0] act;
        logic [19:0] exp;
        act = {bus.Score_first, bus.Score_second, bus.Draws, bus.Round_count,
               bus.Busy, bus.Match_over, bus.Champion};
        exp = {f, s, d, rc, busy, over, ch};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got f=%0d s=%0d d=%0d rc=%0d busy=%b over=%b ch=%b, expected f=%0d s=%0d d=%0d rc=%0d busy=%b over=%b ch=%b",
                     name, act[19:16], act[15:12], act[11:8], act[7:4], act[3], act[2],
                     act[1:0], f, s, d, rc, busy, over, ch);
        end
    endtask

    initial begin
        Reset = 1'b0; bus.Start = 1'b0; bus.Target = 4'd0;
        bus.Round_valid = 1'b0; bus.Out_wr = 2'b00;

        //   name            rst st tgt rv ow      f  s  d  rc busy over champ
        // Target 3, first player wins; Target pin wiggled mid-match has no effect.
        add("reset",         1, 0, 4'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
        add("idle_rv",       0, 0, 4'd0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00);
        add("start_t3",      0, 1, 4'd3, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00);
        add("r1_first",      0, 0, 4'd1, 1, 2'b10, 1, 0, 0, 1, 1, 0, 2'b00);
        add("r2_second",     0, 0, 4'd1, 1, 2'b01, 1, 1, 0, 2, 1, 0, 2'b00);
        add("r3_first",      0, 0, 4'd1, 1, 2'b10, 2, 1, 0, 3, 1, 0, 2'b00);
        add("no_valid",      0, 0, 4'd3, 0, 2'b10, 2, 1, 0, 3, 1, 0, 2'b00);
        add("r4_first_win",  0, 0, 4'd3, 1, 2'b10, 3, 1, 0, 4, 0, 1, 2'b10);
        add("done_rv10",     0, 0, 4'd3, 1, 2'b10, 3, 1, 0, 4, 0, 1, 2'b10);
        add("done_rv01",     0, 0, 4'd3, 1, 2'b01, 3, 1, 0, 4, 0, 1, 2'b10);
        // Target 2, draws and an ignored 00 result; second player wins.
        add("start_t2",      0, 1, 4'd2, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00);
        add("r_draw",        0, 0, 4'd2, 1, 2'b11, 0, 0, 1, 1, 1, 0, 2'b00);
        add("r_none",        0, 0, 4'd2, 1, 2'b00, 0, 0, 1, 1, 1, 0, 2'b00);
        add("r_second",      0, 0, 4'd2, 1, 2'b01, 0, 1, 1, 2, 1, 0, 2'b00);
        add("r_draw2",       0, 0, 4'd2, 1, 2'b11, 0, 1, 2, 3, 1, 0, 2'b00);
        add("r_second_win",  0, 0, 4'd2, 1, 2'b01, 0, 2, 2, 4, 0, 1, 2'b01);
        // Target 0 latches as 1.
        add("start_t0",      0, 1, 4'd0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00);
        add("t0_second_win", 0, 0, 4'd0, 1, 2'b01, 0, 1, 0, 1, 0, 1, 2'b01);
        // Restart mid-match drops the coincident round; reset wins over round.
        add("start_t5",      0, 1, 4'd5, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00);
        add("p_first1",      0, 0, 4'd5, 1, 2'b10, 1, 0, 0, 1, 1, 0, 2'b00);
        add("p_first2",      0, 0, 4'd5, 1, 2'b10, 2, 0, 0, 2, 1, 0, 2'b00);
        add("restart_rv",    0, 1, 4'd5, 1, 2'b10, 0, 0, 0, 0, 1, 0, 2'b00);
        add("after_restart", 0, 0, 4'd5, 1, 2'b10, 1, 0, 0, 1, 1, 0, 2'b00);
        add("reset_rv",      1, 0, 4'd5, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00);
        add("idle_after_rst",0, 0, 4'd5, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00);
        add("start_again",   0, 1, 4'd5, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00);
        add("reset_start",   1, 1, 4'd5, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00);
        add("reset_latch_t", 0, 1, 4'd0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00);
        add("t1_first_win",  0, 0, 4'd0, 1, 2'b10, 1, 0, 0, 1, 0, 1, 2'b10);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].start, vecs[i].target, vecs[i].rv, vecs[i].ow);
            check(vecs[i].name, vecs[i].e_first, vecs[i].e_second, vecs[i].e_draws,
                  vecs[i].e_rounds, vecs[i].e_busy, vecs[i].e_over, vecs[i].e_champ);
        end

        // Target 15: 15 rounds cycling draw/first/second, ends on round limit as a tie.
        begin
            int f, s, d;
            logic [1:0] pat;
            f = 0; s = 0; d = 0;
            step(1'b0, 1'b1, 4'd15, 1'b0, 2'b00);
            check("t15_start", 0, 0, 0, 0, 1, 0, 2'b00);
            for (int i = 0; i < 15; i++) begin
                case (i % 3)
                    0:       begin pat = 2'b11; d++; end
                    1:       begin pat = 2'b10; f++; end
                    default: begin pat = 2'b01; s++; end
                endcase
                step(1'b0, 1'b0, 4'd15, 1'b1, pat);
                if (i == 14) check("t15_limit_tie", 4'(f), 4'(s), 4'(d), 4'd15, 0, 1, 2'b11);
                else         check("t15_round", 4'(f), 4'(s), 4'(d), 4'(i + 1), 1, 0, 2'b00);
            end
            for (int i = 0; i < 3; i++) begin
                step(1'b0, 1'b0, 4'd15, 1'b1, 2'b10);
                check("t15_done_hold", 5, 5, 5, 15, 0, 1, 2'b11);
            end
        end

        // Round limit with unequal scores: 14 first wins and one second win.
        begin
            step(1'b0, 1'b1, 4'd15, 1'b0, 2'b00);
            for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 4'd15, 1'b1, 2'b10);
            check("limit_pre", 14, 0, 0, 14, 1, 0, 2'b00);
            step(1'b0, 1'b0, 4'd15, 1'b1, 2'b01);
            check("limit_first_high", 14, 1, 0, 15, 0, 1, 2'b10);
            step(1'b0, 1'b1, 4'd7, 1'b0, 2'b00);
            check("done_restart", 0, 0, 0, 0, 1, 0, 2'b00);
        end

        // Target reached on the 15th round takes precedence over the round limit.
        begin
            step(1'b0, 1'b1, 4'd8, 1'b0, 2'b00);
            for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 4'd8, 1'b1, 2'b11);
            for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 4'd8, 1'b1, 2'b01);
            check("coinc_pre", 0, 7, 7, 14, 1, 0, 2'b00);
            step(1'b0, 1'b0, 4'd8, 1'b1, 2'b01);
            check("coinc_target", 0, 8, 7, 15, 0, 1, 2'b01);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
